// File: rtl/mouse_packet_decoder.sv
// Decodes PS/2 mouse packets (3-byte standard or 4-byte wheel) into a clamped
// absolute cursor position, a wheel accumulator and the last status byte.
// Malformed or stalled packets are discarded and flagged.
//
// Ports:
//   CLK            system clock, rising edge
//   RESET          asynchronous active-low reset
//   BYTE_IN        received byte, valid while BYTE_READY is high
//   BYTE_READY     one-cycle strobe per received byte
//   BYTE_ERROR     one-cycle strobe per parity/framing error
//   MOUSE_STATUS   byte 1 of the last committed packet
//   MOUSE_X/Y      clamped absolute position (Y grows downwards)
//   MOUSE_Z        accumulated wheel count, two's complement
//   SEND_INTERRUPT one-cycle pulse per committed packet
//   PACKET_ERR     one-cycle pulse per discarded packet
//
// state   | meaning
// WAIT_B1 | idle, waiting for a status byte with bit 3 set
// WAIT_B2 | status latched, waiting for X movement
// WAIT_B3 | waiting for Y movement
// WAIT_B4 | waiting for wheel byte (wheel packets only)
// COMMIT  | one cycle: outputs updated, next byte treated as a WAIT_B1 byte
module mouse_packet_decoder #(
  parameter int MAX_X          = 160,
  parameter int MAX_Y          = 120,
  parameter int Z_ENABLE       = 0,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] BYTE_IN,
  input  logic       BYTE_READY,
  input  logic       BYTE_ERROR,
  output logic [7:0] MOUSE_STATUS,
  output logic [7:0] MOUSE_X,
  output logic [7:0] MOUSE_Y,
  output logic [7:0] MOUSE_Z,
  output logic       SEND_INTERRUPT,
  output logic       PACKET_ERR
);

  localparam int GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {WAIT_B1, WAIT_B2, WAIT_B3, WAIT_B4, COMMIT} state_t;

  state_t             state_q, state_d;
  logic [7:0]         b1_q, b1_d, b2_q, b2_d, b3_q, b3_d, b4_q, b4_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [7:0]         status_q, status_d, x_q, x_d, y_q, y_d, z_q, z_d;
  logic               int_q, int_d, perr_q, perr_d;

  logic signed [10:0] dx, dy, nx, ny;
  logic [7:0]         new_x, new_y, new_z;
  logic               timeout;

  // Movement datapath, evaluated from the latched packet bytes.
  always_comb begin
    dx = '0;
    dy = '0;
    if (!b1_q[6]) dx = {{2{b1_q[4]}}, b1_q[4], b2_q};
    if (!b1_q[7]) dy = {{2{b1_q[5]}}, b1_q[5], b3_q};
    nx = $signed({3'b000, x_q}) + dx;
    // PS/2 Y is positive upwards; the screen Y grows downwards.
    ny = $signed({3'b000, y_q}) - dy;

    if (nx < 0)                 new_x = 8'd0;
    else if (nx >= 11'(MAX_X))  new_x = 8'(MAX_X - 1);
    else                        new_x = nx[7:0];

    if (ny < 0)                 new_y = 8'd0;
    else if (ny >= 11'(MAX_Y))  new_y = 8'(MAX_Y - 1);
    else                        new_y = ny[7:0];

    new_z = z_q + {{4{b4_q[3]}}, b4_q[3:0]};
  end

  // Fires on the edge where the gap since the last byte reaches the limit.
  assign timeout = !BYTE_READY && (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    b1_d     = b1_q;
    b2_d     = b2_q;
    b3_d     = b3_q;
    b4_d     = b4_q;
    status_d = status_q;
    x_d      = x_q;
    y_d      = y_q;
    z_d      = z_q;
    int_d    = 1'b0;
    perr_d   = 1'b0;

    if (BYTE_READY)                                       gap_d = '0;
    else if (state_q inside {WAIT_B2, WAIT_B3, WAIT_B4})  gap_d = gap_q + 1'b1;
    else                                                  gap_d = '0;

    case (state_q)
      WAIT_B1, COMMIT: begin
        if (state_q == COMMIT) begin
          status_d = b1_q;
          x_d      = new_x;
          y_d      = new_y;
          if (Z_ENABLE != 0) z_d = new_z;
          int_d    = 1'b1;
        end
        // COMMIT also screens the incoming byte so back-to-back packets
        // lose nothing; an error here has no partial packet to discard.
        state_d = WAIT_B1;
        if (!BYTE_ERROR && BYTE_READY && BYTE_IN[3]) begin
          b1_d    = BYTE_IN;
          state_d = WAIT_B2;
        end
      end
      WAIT_B2, WAIT_B3, WAIT_B4: begin
        if (BYTE_ERROR || timeout) begin
          state_d = WAIT_B1;
          perr_d  = 1'b1;
          gap_d   = '0;
        end else if (BYTE_READY) begin
          case (state_q)
            WAIT_B2: begin
              b2_d    = BYTE_IN;
              state_d = WAIT_B3;
            end
            WAIT_B3: begin
              b3_d    = BYTE_IN;
              state_d = (Z_ENABLE != 0) ? WAIT_B4 : COMMIT;
            end
            default: begin
              b4_d    = BYTE_IN;
              state_d = COMMIT;
            end
          endcase
        end
      end
      default: state_d = WAIT_B1;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q  <= WAIT_B1;
      b1_q     <= '0;
      b2_q     <= '0;
      b3_q     <= '0;
      b4_q     <= '0;
      gap_q    <= '0;
      status_q <= 8'h00;
      x_q      <= 8'(MAX_X / 2);
      y_q      <= 8'(MAX_Y / 2);
      z_q      <= 8'h00;
      int_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      b1_q     <= b1_d;
      b2_q     <= b2_d;
      b3_q     <= b3_d;
      b4_q     <= b4_d;
      gap_q    <= gap_d;
      status_q <= status_d;
      x_q      <= x_d;
      y_q      <= y_d;
      z_q      <= z_d;
      int_q    <= int_d;
      perr_q   <= perr_d;
    end
  end

  assign MOUSE_STATUS   = status_q;
  assign MOUSE_X        = x_q;
  assign MOUSE_Y        = y_q;
  assign MOUSE_Z        = z_q;
  assign SEND_INTERRUPT = int_q;
  assign PACKET_ERR     = perr_q;

endmodule
